pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage ARM pipeline (IF/ID/EXE/MEM/WB).
- Detects RAW data hazards between the instruction in ID and the EXE/MEM stages.
- Freezes the whole pipeline while a MEM-stage SRAM access waits for ready.
- Generates branch flushes.
- Drives the `hazard` input of the ID stage and the freeze/flush enables of every pipeline register.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl_raw_detect.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding, register-index width and
//                default timeout / counter sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Register index width (R0..R15, R15 is the PC and is not special-cased)
    localparam int REG_W            = 4;

    // Default number of MEM_WAIT cycles before the SRAM timeout flag is set
    localparam int MEM_TIMEOUT_DFLT = 64;

    // Default width of the stall performance counter
    localparam int CNT_W_DFLT       = 16;

    // Sequencer states; explicit one-bit encoding
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the pipeline stages and the hazard
//                controller. The master side (pipeline) drives the stage
//                fields; the slave side (controller) drives the
//                stall/flush enables and the status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = CNT_W_DFLT
) ();

    // Pipeline stage fields
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             id_valid;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;

    // Controller outputs
    logic             hazard;
    logic             freeze_if;
    logic             freeze_id;
    logic             freeze_exe;
    logic             freeze_mem;
    logic             flush_if;
    logic             flush_id;
    logic             mem_err;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_src1, id_src2, id_two_src, id_valid,
        output exe_dest, exe_wb_en, exe_mem_read,
        output mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
        input  hazard, freeze_if, freeze_id, freeze_exe, freeze_mem,
        input  flush_if, flush_id, mem_err, stall_count
    );

    modport slave (
        input  id_src1, id_src2, id_two_src, id_valid,
        input  exe_dest, exe_wb_en, exe_mem_read,
        input  mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
        output hazard, freeze_if, freeze_id, freeze_exe, freeze_mem,
        output flush_if, flush_id, mem_err, stall_count
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_raw_detect.sv
`default_nettype none
// ============================================================================
//  Module      : raw_detect
//  Description : Combinational RAW comparator between the instruction in ID
//                and the destinations in EXE and MEM.
//                Build option FORWARDING_EN: the datapath forwards from EXE
//                and MEM, so only a load in EXE feeding ID (load-use) stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module raw_detect
    import pipe_pkg::*;
(
    input  wire logic [REG_W-1:0] i_id_src1,
    input  wire logic [REG_W-1:0] i_id_src2,
    input  wire logic             i_id_two_src,
    input  wire logic             i_id_valid,
    input  wire logic [REG_W-1:0] i_exe_dest,
    input  wire logic             i_exe_wb_en,
    input  wire logic             i_exe_mem_read,
    input  wire logic [REG_W-1:0] i_mem_dest,
    input  wire logic             i_mem_wb_en,
    output logic                  o_hazard
);

    logic w_m1;
    logic w_m2;
    logic w_m3;
    logic w_m4;
    logic w_unused;

`ifdef FORWARDING_EN
    // Only a load in EXE cannot be forwarded in time; MEM results always can
    assign w_m1     = i_exe_wb_en & i_exe_mem_read & (i_exe_dest == i_id_src1);
    assign w_m2     = i_id_two_src & i_exe_wb_en & i_exe_mem_read
                    & (i_exe_dest == i_id_src2);
    assign w_m3     = 1'b0;
    assign w_m4     = 1'b0;
    assign w_unused = ^{i_mem_dest, i_mem_wb_en};
`else
    // No forwarding path: any pending write to a source register stalls
    assign w_m1     = i_exe_wb_en & (i_exe_dest == i_id_src1);
    assign w_m2     = i_id_two_src & i_exe_wb_en & (i_exe_dest == i_id_src2);
    assign w_m3     = i_mem_wb_en & (i_mem_dest == i_id_src1);
    assign w_m4     = i_id_two_src & i_mem_wb_en & (i_mem_dest == i_id_src2);
    assign w_unused = i_exe_mem_read;
`endif

    // A null instruction in ID has no sources to protect
    assign o_hazard = i_id_valid & (w_m1 | w_m2 | w_m3 | w_m4);

endmodule : raw_detect
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline. Freezes all
//                stages during an outstanding SRAM access, flushes IF/ID and
//                ID/EXE on a taken branch, and inserts a bubble on a RAW
//                hazard. Also keeps a sticky SRAM timeout flag and a
//                saturating freeze-cycle counter.
//                Build option FORWARDING_EN: restrict RAW stalls to
//                load-use (applied inside raw_detect).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DFLT,
    parameter int CNT_W       = CNT_W_DFLT
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave bus
);

    // Wait counter only has to reach MEM_TIMEOUT-1, where it parks
    localparam int                  C_WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    logic [C_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;
    logic [CNT_W-1:0]    r_stall_count;

    logic w_raw;
    logic w_mem_stall;
    logic w_hazard;
    logic w_freeze_if;
    logic w_freeze_id;
    logic w_freeze_exe;
    logic w_freeze_mem;
    logic w_flush_if;
    logic w_flush_id;

    raw_detect u_raw_detect (
        .i_id_src1      (bus.id_src1),
        .i_id_src2      (bus.id_src2),
        .i_id_two_src   (bus.id_two_src),
        .i_id_valid     (bus.id_valid),
        .i_exe_dest     (bus.exe_dest),
        .i_exe_wb_en    (bus.exe_wb_en),
        .i_exe_mem_read (bus.exe_mem_read),
        .i_mem_dest     (bus.mem_dest),
        .i_mem_wb_en    (bus.mem_wb_en),
        .o_hazard       (w_raw)
    );

    // A request without ready stalls in either state; a request dropped in
    // MEM_WAIT without ready is treated as completion, which this covers.
    assign w_mem_stall = bus.mem_req & ~bus.mem_ready;

    // Priority mux: memory wait > branch > data hazard; all quiet in reset.
    // Branch and RAW are also honoured in the MEM_WAIT release cycle, since
    // the pipeline advances in that cycle exactly as in RUN.
    always_comb begin
        w_hazard     = 1'b0;
        w_freeze_if  = 1'b0;
        w_freeze_id  = 1'b0;
        w_freeze_exe = 1'b0;
        w_freeze_mem = 1'b0;
        w_flush_if   = 1'b0;
        w_flush_id   = 1'b0;
        if (!rst) begin
            if (w_mem_stall) begin
                w_freeze_if  = 1'b1;
                w_freeze_id  = 1'b1;
                w_freeze_exe = 1'b1;
                w_freeze_mem = 1'b1;
            end else if (bus.branch_taken) begin
                w_flush_if   = 1'b1;
                w_flush_id   = 1'b1;
            end else if (w_raw) begin
                // Hold IF/ID; ID/EXE keeps loading and picks up the bubble
                w_hazard     = 1'b1;
                w_freeze_if  = 1'b1;
            end
        end
    end

    // Sequencer state, SRAM wait counter, sticky timeout and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_err     <= 1'b0;
            r_stall_count <= '0;
        end else begin
            // freeze_if is set whenever any freeze is set
            if (w_freeze_if && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            case (r_state)
                RUN: begin
                    r_wait_cnt <= '0;
                    if (w_mem_stall) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (w_mem_stall) begin
                        // Keep waiting after a timeout; only the flag is raised
                        if (r_wait_cnt == C_WAIT_LAST) begin
                            r_mem_err <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
                        end
                    end else begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.hazard      = w_hazard;
    assign bus.freeze_if   = w_freeze_if;
    assign bus.freeze_id   = w_freeze_id;
    assign bus.freeze_exe  = w_freeze_exe;
    assign bus.freeze_mem  = w_freeze_mem;
    assign bus.flush_if    = w_flush_if;
    assign bus.flush_id    = w_flush_id;
    // Registered status is masked so it reads 0 from the first reset cycle
    assign bus.mem_err     = r_mem_err & ~rst;
    assign bus.stall_count = rst ? '0 : r_stall_count;

endmodule : pipe_hazard_ctrl
`default_nettype wire
